// File: rtl/conv3x3_stream_if.sv
// Stream and coefficient-port bundle for conv3x3_stream.
// pix_valid is a one-way strobe with no ready: every cycle it is high, pix_in/sof are consumed.
interface conv3x3_stream_if #(
  parameter int PIX_W  = 4,
  parameter int COEF_W = 5
);
  logic [PIX_W-1:0]         pix_in;
  logic                     pix_valid;
  logic                     sof;
  logic                     coef_we;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic [PIX_W-1:0]         pix_out;
  logic                     pix_out_valid;
  logic                     border_out;
  logic                     frame_done;

  modport master (
    output pix_in, pix_valid, sof, coef_we, coef_addr, coef_data,
    input  pix_out, pix_out_valid, border_out, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof, coef_we, coef_addr, coef_data,
    output pix_out, pix_out_valid, border_out, frame_done
  );
endinterface

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution with two line buffers, programmable signed kernel and saturating output.
// Optional macro CONV_ABS_EN: take |sum| before the shift so negative responses map to magnitude.
module conv3x3_stream #(
  parameter int PIX_W  = 4,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int COEF_W = 5,
  parameter int SHIFT  = 3
) (
  input logic clk,
  input logic rst,
  conv3x3_stream_if.slave bus
);
  localparam int CW      = $clog2(IMG_W);
  localparam int RW      = $clog2(IMG_H);
  localparam int PW      = COEF_W + PIX_W + 1;
  localparam int SW      = PW + 4;
  localparam int MAX_PIX = (1 << PIX_W) - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [COEF_W-1:0] r_coef [9];
  logic [PIX_W-1:0]         r_lb1 [IMG_W];
  logic [PIX_W-1:0]         r_lb2 [IMG_W];
  logic [PIX_W-1:0]         r_win [3][2];

  logic signed [PW-1:0]     r_prod [9];
  logic                     r_s1_valid;
  logic                     r_s1_border;
  logic                     r_s1_last;

  logic [PIX_W-1:0]         r_pix_out;
  logic                     r_out_valid;
  logic                     r_border_out;
  logic                     r_frame_done;

  logic [CW-1:0]            w_col_eff;
  logic [RW-1:0]            w_row_eff;
  logic                     w_emit;
  logic                     w_border;
  logic                     w_last;
  logic [PIX_W-1:0]         w_win_nx [3][3];
  logic signed [PW-1:0]     w_prod [9];
  logic signed [SW-1:0]     w_sum;
  logic signed [SW-1:0]     w_mag;
  logic signed [SW-1:0]     w_shift;
  logic [PIX_W-1:0]         w_sat;

  // sof pins the accepted sample to (0,0) whatever the counters say.
  always_comb begin
    w_col_eff = bus.sof ? '0 : r_col;
    w_row_eff = bus.sof ? '0 : r_row;
    w_emit    = (w_row_eff >= RW'(2)) || ((w_row_eff == RW'(1)) && (w_col_eff != '0));
    w_border  = (w_col_eff == '0) || (w_col_eff == CW'(1)) || (w_row_eff == RW'(1));
    w_last    = (w_row_eff == ROW_LAST) && (w_col_eff == COL_LAST);
  end

  // Window after this sample shifts in: newest column on the right, centre is one line and one pixel back.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_nx[r][0] = r_win[r][0];
      w_win_nx[r][1] = r_win[r][1];
    end
    w_win_nx[0][2] = r_lb2[w_col_eff];
    w_win_nx[1][2] = r_lb1[w_col_eff];
    w_win_nx[2][2] = bus.pix_in;
    for (int k = 0; k < 9; k++) begin
      w_prod[k] = PW'(r_coef[k]) * PW'($signed({1'b0, w_win_nx[k / 3][k % 3]}));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.pix_valid) begin
      if (w_col_eff == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row_eff == ROW_LAST) ? '0 : w_row_eff + RW'(1);
      end else begin
        r_col <= w_col_eff + CW'(1);
        r_row <= w_row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        r_coef[k] <= (k == 4) ? COEF_W'(1 << SHIFT) : '0;
      end
    end else if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      r_lb2[w_col_eff] <= r_lb1[w_col_eff];
      r_lb1[w_col_eff] <= bus.pix_in;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= w_win_nx[r][1];
        r_win[r][1] <= w_win_nx[r][2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_last   <= 1'b0;
      for (int k = 0; k < 9; k++) r_prod[k] <= '0;
    end else begin
      r_s1_valid <= bus.pix_valid && w_emit;
      if (bus.pix_valid) begin
        r_s1_border <= w_border;
        r_s1_last   <= w_last;
        for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) w_sum = w_sum + SW'(r_prod[k]);
`ifdef CONV_ABS_EN
    w_mag = (w_sum < 0) ? -w_sum : w_sum;
`else
    w_mag = w_sum;
`endif
    w_shift = w_mag >>> SHIFT;
    if (w_shift < 0)
      w_sat = '0;
    else if (int'(w_shift) > MAX_PIX)
      w_sat = PIX_W'(MAX_PIX);
    else
      w_sat = w_shift[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_out    <= '0;
      r_out_valid  <= 1'b0;
      r_border_out <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= r_s1_valid;
      r_frame_done <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_pix_out    <= r_s1_border ? '0 : w_sat;
        r_border_out <= r_s1_border;
      end
    end
  end

  assign bus.pix_out       = r_pix_out;
  assign bus.pix_out_valid = r_out_valid;
  assign bus.border_out    = r_border_out;
  assign bus.frame_done    = r_frame_done;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on an 8x4 image: a frame-array reference model queues
// expected results with their due cycle, a negedge monitor pops and compares.
module tb_conv3x3_stream;
  localparam int PIX_W  = 4;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int COEF_W = 5;
  localparam int SHIFT  = 3;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int QW     = 16 + 2 + PIX_W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_stream_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

  conv3x3_stream #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .COEF_W(COEF_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [QW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  int m_n;
  int m_coef[9];
  int m_img[NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] stamp_of(input logic [QW-1:0] e);
    return e[QW-1:PIX_W+2];
  endfunction

  function automatic void model_reset();
    m_n = 0;
    for (int k = 0; k < 9; k++) m_coef[k] = (k == 4) ? (1 << SHIFT) : 0;
  endfunction

  // Reference: keep the whole frame, convolve around centre n-IMG_W-1 with plain integer arithmetic.
  task automatic model_accept(input logic [PIX_W-1:0] p, input bit s, input int stamp);
    int c, cr, cc, sum, v;
    bit bord, fd;
    logic [15:0] st;
    logic [PIX_W-1:0] pv;
    if (s) m_n = 0;
    m_img[m_n] = int'(p);
    if (m_n >= IMG_W + 1) begin
      c    = m_n - IMG_W - 1;
      cr   = c / IMG_W;
      cc   = c % IMG_W;
      bord = (cr == 0) || (cc == 0) || (cc == IMG_W - 1);
      v    = 0;
      if (!bord) begin
        sum = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            sum += m_coef[(dr + 1) * 3 + dc + 1] * m_img[(cr + dr) * IMG_W + cc + dc];
`ifdef CONV_ABS_EN
        if (sum < 0) sum = -sum;
`endif
        v = sum >>> SHIFT;
        if (v < 0) v = 0;
        if (v > (1 << PIX_W) - 1) v = (1 << PIX_W) - 1;
      end
      fd = (m_n == NPIX - 1);
      st = stamp[15:0];
      pv = v[PIX_W-1:0];
      exp_q.push_back({st, fd, bord, pv});
    end
    m_n = (m_n + 1) % NPIX;
  endtask

  task automatic step(input bit v, input logic [PIX_W-1:0] p, input bit s,
                      input bit we, input logic [3:0] a, input logic [COEF_W-1:0] d);
    bus.pix_valid = v;
    bus.pix_in    = p;
    bus.sof       = s;
    bus.coef_we   = we;
    bus.coef_addr = a;
    bus.coef_data = d;
    if (v) model_accept(p, s, cyc + 2);
    if (we && a <= 4'd8) m_coef[a] = int'($signed(d));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 4'd0, '0);
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [COEF_W-1:0] d);
    step(1'b0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic set_kernel(input logic [COEF_W-1:0] other, input logic [COEF_W-1:0] centre);
    for (int k = 0; k < 9; k++) wr_coef(4'(k), (k == 4) ? centre : other);
  endtask

  task automatic frame_const(input logic [PIX_W-1:0] p);
    for (int i = 0; i < NPIX; i++) step(1'b1, p, i == 0, 1'b0, 4'd0, '0);
  endtask

  task automatic frame_ramp();
    for (int i = 0; i < NPIX; i++) step(1'b1, 4'(i % 16), i == 0, 1'b0, 4'd0, '0);
  endtask

  task automatic frame_random(input int count, input bit gaps, input bit coef_noise);
    int  i;
    bit  v, we;
    i = 0;
    while (i < count) begin
      v  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      we = coef_noise && ($urandom_range(0, 4) == 0);
      step(v, 4'($urandom_range(0, 15)), v && (i == 0), we,
           4'($urandom_range(0, 10)), 5'($urandom_range(0, 31)));
      if (v) i++;
    end
  endtask

  always @(negedge clk) begin
    logic [QW-1:0] e;
    logic [QW-1:0] got;
    if (mon_en) begin
      if (exp_q.size() > 0 && stamp_of(exp_q[0]) < cyc[15:0]) begin
        e = exp_q.pop_front();
        check("missing_output_cycle", {16'h0, cyc[15:0]}, {16'h0, stamp_of(e)});
      end
      if (bus.pix_out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'h0, bus.pix_out_valid}, 32'h0);
        end else begin
          e   = exp_q.pop_front();
          got = {cyc[15:0], bus.frame_done, bus.border_out, bus.pix_out};
          check("result{cyc,fd,border,pix}", 32'(got), 32'(e));
        end
      end else if (bus.frame_done) begin
        check("frame_done_without_valid", {31'h0, bus.frame_done}, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.sof       = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_pix_out", 32'(bus.pix_out), 32'h0);
    check("reset_valid", 32'(bus.pix_out_valid), 32'h0);
    check("reset_border", 32'(bus.border_out), 32'h0);
    check("reset_frame_done", 32'(bus.frame_done), 32'h0);
    mon_en = 1'b1;

    // Identity kernel straight out of reset.
    frame_ramp();
    idle(4);

    // Box kernel: 8 -> 9, 15 saturates.
    set_kernel(5'd1, 5'd1);
    frame_const(4'd8);
    frame_const(4'd15);
    idle(4);

    // Laplacian: flat field cancels, isolated bright pixel.
    set_kernel(5'h1F, 5'd8);
    frame_const(4'd5);
    for (int i = 0; i < NPIX; i++) step(1'b1, (i == 11) ? 4'd15 : 4'd0, i == 0, 1'b0, 4'd0, '0);
    idle(4);

    // Random data, random valid gaps, random coefficient writes (some out of range, some with pix_valid).
    for (int f = 0; f < 3; f++) frame_random(NPIX, 1'b1, 1'b1);
    idle(4);

    // sof at n=20 aborts the frame, then a full new frame.
    frame_random(20, 1'b0, 1'b0);
    frame_random(NPIX, 1'b0, 1'b0);
    idle(4);

    // Reset mid-frame: pipeline flushed and kernel back to identity.
    frame_random(15, 1'b0, 1'b0);
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.coef_we   = 1'b0;
    while (exp_q.size() > 0 && stamp_of(exp_q[$]) > cyc[15:0]) void'(exp_q.pop_back());
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("valid_after_mid_rst", 32'(bus.pix_out_valid), 32'h0);
    idle(3);
    frame_ramp();
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
